counter_snapshot_reader: RTL and testbench
==========================================

Name: counter_snapshot_reader

Overview:
Sequencer that shares a bank of NCHAN updown_counter outputs with a single 8-bit host read port. On a snapshot request it latches every channel count in the same clock edge, so all wheels are sampled coherently. It then streams the latched values byte by byte over a valid/ready handshake. It sits between the encoder counter bank and the host (AVR) bus interface.

Parameters:
NCHAN, 4, number of counter channels (1..8)
SIZE, 8, width of each counter in bits (1..16); BYTES = (SIZE+7)/8 bytes per channel

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
count  in  NCHAN*SIZE  flattened counter outputs; channel i at [i*SIZE +: SIZE]
snap  in  1  snapshot request, sampled each rising edge
busy  out  1  transfer in progress (state SEND)
data  out  8  current output byte
valid  out  1  data is valid
ready  in  1  host accepts data this cycle
last  out  1  data is the final byte of the snapshot
overrun  out  1  sticky flag: snap requested while busy

Behaviour:
- Reset (rst=1 at rising edge): state IDLE; busy=0, valid=0, last=0, data=8'h00, overrun=0. Shadow registers cleared to 0. Reset has priority over every other input, including mid-transfer: the transfer is aborted with no further bytes.
- States:
  - IDLE: valid=0.
  - SEND: valid=1, busy=1.
- IDLE with snap=1 at an edge: all NCHAN counts captured into shadow registers at that edge; channel index=0, byte index=0; enter SEND. First byte valid in the cycle after snap (latency 1).
- Byte order: channel 0 first, ascending channel. Within a channel, least significant byte first. Bits above SIZE in the top byte are zero.
- SEND: a handshake is valid=1 and ready=1 at a rising edge. On a handshake, advance to the next byte. With no handshake, data, last and the indices hold stable.
- last=1 exactly while the presented byte is byte BYTES-1 of channel NCHAN-1. A handshake on that byte returns to IDLE: valid=0 and busy=0 next cycle.
- Back-to-back: snap=1 in the same cycle as the final handshake starts a new snapshot. Counts are captured at that edge, state stays SEND, valid is not deasserted, and overrun is not set.
- snap=1 in SEND, other than during the final handshake: ignored and overrun set to 1. The shadow registers are not modified. overrun clears only on an accepted snap or on reset; an accepted snap clears it in the same edge.
- Total bytes per snapshot = NCHAN*BYTES. Minimum transfer time is NCHAN*BYTES cycles with ready held at 1.
- Counter wrap is not interpreted. Raw two's-complement bits are transferred; the host computes differences modulo 2^SIZE.
- Count inputs changing during SEND have no effect on the transfer.

Decomposition:
- Shared package/include: state encodings (ST_IDLE, ST_SEND) and a BYTES computation macro/function, reused by the host bus interface.
- One sub-module is natural: snapshot_bank. It holds the NCHAN×SIZE shadow registers with a capture enable and a channel/byte select mux producing the 8-bit data. The top level holds the FSM, indices, last, busy and overrun.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, snap=0 → valid=0, busy=0, data=00, overrun=0 throughout.
- Basic transfer, defaults (NCHAN=4, SIZE=8): counts 12,34,56,78 (hex), snap pulse, ready=1 → bytes 12,34,56,78 on 4 consecutive cycles starting 1 cycle after snap; last only on 78; valid=0 on the fifth cycle.
- Backpressure and coherence, SIZE=12: counts ch0=ABC, ch1=123; snap; ready toggled 0/1; count inputs changed during transfer → bytes BC,0A,23,01 in order. Each byte is held stable while ready=0, and the new count values never appear.
- Overrun: snap pulse mid-transfer (after 2 of 4 bytes) → overrun=1, byte stream unchanged. The next snap in IDLE clears overrun and starts a fresh transfer.
- Back-to-back: snap asserted on the cycle of the final handshake → valid stays 1, next byte is channel 0 byte 0 of the new counts, overrun stays 0.
- Reset mid-operation: rst=1 after the first byte while valid=1 → next cycle valid=0, busy=0, last=0, and no further bytes until a new snap.

Source files
------------

// File: rtl/counter_snapshot_reader_pkg.sv
// Shared definitions for the counter snapshot reader and the host bus side.
// Holds the sequencer state encoding and the bytes-per-channel helper.
package counter_snapshot_reader_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_e;

   // Bytes needed to carry one SIZE-bit counter, LSB byte first.
   function automatic int unsigned bytes_of(input int unsigned size);
      return (size + 7) / 8;
   endfunction

endpackage

// File: rtl/counter_snapshot_reader_snapshot_bank.sv
// Shadow registers for all counter channels plus the channel/byte read mux.
// Ports: clk_i, rst_i (sync, high), capture_i, count_i, chan_i, byte_i,
//        data_o (selected byte, bits above SIZE read as zero).
module snapshot_bank
   import counter_snapshot_reader_pkg::*;
#(
   parameter int unsigned NCHAN = 4,
   parameter int unsigned SIZE  = 8,
   parameter int unsigned CW    = 2,
   parameter int unsigned BW    = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  capture_i,
   input  logic [NCHAN*SIZE-1:0] count_i,
   input  logic [CW-1:0]         chan_i,
   input  logic [BW-1:0]         byte_i,
   output logic [7:0]            data_o
);

   localparam int unsigned BYTES = bytes_of(SIZE);

   logic [SIZE-1:0]    shadow_q [NCHAN];
   logic [SIZE-1:0]    sel;
   logic [BYTES*8-1:0] word;

   // All channels load on the same edge so the host sees one coherent sample.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NCHAN; i++) begin
            shadow_q[i] <= '0;
         end
      end else if (capture_i) begin
         for (int i = 0; i < NCHAN; i++) begin
            shadow_q[i] <= count_i[i*SIZE +: SIZE];
         end
      end
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < NCHAN; i++) begin
         if (chan_i == CW'(i)) begin
            sel = shadow_q[i];
         end
      end
   end

   always_comb begin
      word = '0;
      word[SIZE-1:0] = sel;
      data_o = '0;
      for (int b = 0; b < BYTES; b++) begin
         if (byte_i == BW'(b)) begin
            data_o = word[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/counter_snapshot_reader.sv
// Snapshots NCHAN counters in one edge and streams them as bytes to the host.
// Ports: clk, rst (sync, high), count, snap, ready in; busy, data, valid,
//        last, overrun out. Channel 0 first, LSB byte first.
module counter_snapshot_reader
   import counter_snapshot_reader_pkg::*;
#(
   parameter int unsigned NCHAN = 4,
   parameter int unsigned SIZE  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCHAN*SIZE-1:0] count,
   input  logic                  snap,
   output logic                  busy,
   output logic [7:0]            data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  last,
   output logic                  overrun
);

   localparam int unsigned BYTES = bytes_of(SIZE);
   localparam int unsigned CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
   localparam int unsigned BW = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [CW-1:0] CH_LAST = CW'(NCHAN - 1);
   localparam logic [BW-1:0] BY_LAST = BW'(BYTES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] chan_q, chan_d;
   logic [BW-1:0] byte_q, byte_d;
   logic          ovr_q, ovr_d;

   logic is_last;
   logic fin_hs;
   logic capture;

   assign is_last = (chan_q == CH_LAST) && (byte_q == BY_LAST);
   assign fin_hs  = (state_q == ST_SEND) && ready && is_last;
   // A snap on the final handshake chains straight into the next snapshot.
   assign capture = snap && ((state_q == ST_IDLE) || fin_hs);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         chan_q  <= '0;
         byte_q  <= '0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         chan_q  <= chan_d;
         byte_q  <= byte_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      byte_d  = byte_q;
      ovr_d   = ovr_q;
      unique case (state_q)
         ST_IDLE: begin
            if (snap) begin
               state_d = ST_SEND;
               chan_d  = '0;
               byte_d  = '0;
               ovr_d   = 1'b0;
            end
         end
         ST_SEND: begin
            unique case (1'b1)
               !ready: begin
               end
               ready && is_last && snap: begin
                  chan_d = '0;
                  byte_d = '0;
                  ovr_d  = 1'b0;
               end
               ready && is_last && !snap: begin
                  state_d = ST_IDLE;
                  chan_d  = '0;
                  byte_d  = '0;
               end
               ready && !is_last && (byte_q == BY_LAST): begin
                  byte_d = '0;
                  chan_d = chan_q + 1'b1;
               end
               ready && !is_last && (byte_q != BY_LAST): begin
                  byte_d = byte_q + 1'b1;
               end
               default: begin
               end
            endcase
            if (snap && !fin_hs) begin
               ovr_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      valid   = (state_q == ST_SEND);
      busy    = valid;
      last    = valid && is_last;
      overrun = ovr_q;
   end

   snapshot_bank #(
      .NCHAN(NCHAN),
      .SIZE (SIZE),
      .CW   (CW),
      .BW   (BW)
   ) u_bank (
      .clk_i    (clk),
      .rst_i    (rst),
      .capture_i(capture),
      .count_i  (count),
      .chan_i   (chan_q),
      .byte_i   (byte_q),
      .data_o   (data)
   );

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// Bench for counter_snapshot_reader: two instances (4x8 and 3x12) against
// a byte-queue reference model, directed scenarios then random traffic.
module tb_counter_snapshot_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        snap;
   logic        ready;
   logic [31:0] count_a;
   logic [35:0] count_b;

   logic       busy_a, valid_a, last_a, ovr_a;
   logic       busy_b, valid_b, last_b, ovr_b;
   logic [7:0] data_a, data_b;

   always #5 clk = ~clk;

   counter_snapshot_reader #(.NCHAN(4), .SIZE(8)) dut_a (
      .clk    (clk),
      .rst    (rst),
      .count  (count_a),
      .snap   (snap),
      .busy   (busy_a),
      .data   (data_a),
      .valid  (valid_a),
      .ready  (ready),
      .last   (last_a),
      .overrun(ovr_a)
   );

   counter_snapshot_reader #(.NCHAN(3), .SIZE(12)) dut_b (
      .clk    (clk),
      .rst    (rst),
      .count  (count_b),
      .snap   (snap),
      .busy   (busy_b),
      .data   (data_b),
      .valid  (valid_b),
      .ready  (ready),
      .last   (last_b),
      .overrun(ovr_b)
   );

   logic       vld [2];
   logic       bsy [2];
   logic       lst [2];
   logic       ovf [2];
   logic [7:0] dat [2];

   assign vld[0] = valid_a;
   assign vld[1] = valid_b;
   assign bsy[0] = busy_a;
   assign bsy[1] = busy_b;
   assign lst[0] = last_a;
   assign lst[1] = last_b;
   assign ovf[0] = ovr_a;
   assign ovf[1] = ovr_b;
   assign dat[0] = data_a;
   assign dat[1] = data_b;

   int n_chk  = 0;
   int n_fail = 0;
   bit en     = 1'b0;

   // Model: bytes still owed to the host, head is the presented byte.
   logic [7:0] mq  [2][$];
   logic [7:0] acc [2][$];
   bit         mov [2];
   bit         fin;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void load(input int d);
      logic [63:0] flat;
      int n, s;
      flat = (d == 0) ? 64'(count_a) : 64'(count_b);
      n = (d == 0) ? 4 : 3;
      s = (d == 0) ? 8 : 12;
      mq[d].delete();
      for (int c = 0; c < n; c++) begin
         logic [63:0] v;
         v = (flat >> (c * s)) & ((64'd1 << s) - 64'd1);
         for (int b = 0; b < (s + 7) / 8; b++) begin
            mq[d].push_back(v[8*b +: 8]);
         end
      end
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            mq[d].delete();
            mov[d] = 1'b0;
         end else if (mq[d].size() != 0) begin
            fin = ready && (mq[d].size() == 1);
            if (ready) void'(mq[d].pop_front());
            if (snap && fin) begin
               load(d);
               mov[d] = 1'b0;
            end else if (snap) begin
               mov[d] = 1'b1;
            end
         end else if (snap) begin
            load(d);
            mov[d] = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (en) begin
         for (int d = 0; d < 2; d++) begin
            logic ev;
            ev = (mq[d].size() != 0);
            chk($sformatf("d%0d.valid", d), 32'(vld[d]), 32'(ev));
            chk($sformatf("d%0d.busy", d), 32'(bsy[d]), 32'(ev));
            chk($sformatf("d%0d.last", d), 32'(lst[d]),
                32'(ev && (mq[d].size() == 1)));
            chk($sformatf("d%0d.overrun", d), 32'(ovf[d]), 32'(mov[d]));
            if (ev) begin
               chk($sformatf("d%0d.data", d), 32'(dat[d]), 32'(mq[d][0]));
            end
            if (vld[d] && ready) acc[d].push_back(dat[d]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      ready = 1'b1;
      snap  = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (mq[0].size() == 0 && mq[1].size() == 0) break;
         tick();
      end
      if (mq[0].size() != 0 || mq[1].size() != 0) begin
         chk("idle_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic check_acc(input int d, input logic [7:0] e[$]);
      chk($sformatf("d%0d.nbytes", d), 32'(acc[d].size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < acc[d].size(); i++) begin
         chk($sformatf("d%0d.byte%0d", d, i), 32'(acc[d][i]), 32'(e[i]));
      end
   endtask

   logic [7:0] e[$];

   initial begin
      rst     = 1'b1;
      snap    = 1'b0;
      ready   = 1'b0;
      count_a = 32'h0;
      count_b = 36'h0;
      tick();
      en = 1'b1;
      tick();
      @(negedge clk);
      chk("rst.data_a", 32'(data_a), 32'h00);
      chk("rst.data_b", 32'(data_b), 32'h00);
      chk("rst.valid_a", 32'(valid_a), 32'h0);
      chk("rst.ovr_a", 32'(ovr_a), 32'h0);
      rst = 1'b0;
      tick();

      // Basic transfer on the default geometry.
      wait_idle();
      count_a = 32'h78563412;
      acc[0].delete();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      @(negedge clk);
      chk("basic.first", 32'(data_a), 32'h12);
      wait_idle();
      e = '{8'h12, 8'h34, 8'h56, 8'h78};
      check_acc(0, e);

      // Backpressure with count inputs moving after the snapshot.
      count_b = {12'h7FF, 12'h123, 12'hABC};
      acc[1].delete();
      ready = 1'b0;
      snap  = 1'b1;
      tick();
      snap = 1'b0;
      for (int i = 0; i < 16; i++) begin
         ready   = i[0];
         count_a = $urandom;
         count_b = {4'($urandom), 32'($urandom)};
         tick();
      end
      wait_idle();
      e = '{8'hBC, 8'h0A, 8'h23, 8'h01, 8'hFF, 8'h07};
      check_acc(1, e);

      // Overrun raised mid-transfer, cleared by the next accepted snap.
      snap = 1'b1;
      tick();
      snap = 1'b0;
      tick();
      tick();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      @(negedge clk);
      chk("ovr.set", 32'(ovr_a), 32'h1);
      wait_idle();
      @(negedge clk);
      chk("ovr.sticky", 32'(ovr_a), 32'h1);
      snap = 1'b1;
      tick();
      snap = 1'b0;
      @(negedge clk);
      chk("ovr.clear", 32'(ovr_a), 32'h0);
      chk("ovr.restart", 32'(valid_a), 32'h1);

      // Back-to-back: snap on the final handshake of dut_a.
      wait_idle();
      acc[0].delete();
      count_a = 32'h44332211;
      snap = 1'b1;
      tick();
      snap = 1'b0;
      count_a = 32'hDDCCBBAA;
      tick();
      tick();
      tick();
      snap = 1'b1;
      tick();
      snap = 1'b0;
      @(negedge clk);
      chk("b2b.valid", 32'(valid_a), 32'h1);
      chk("b2b.data", 32'(data_a), 32'hAA);
      chk("b2b.ovr", 32'(ovr_a), 32'h0);
      wait_idle();
      e = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      check_acc(0, e);

      // Reset mid-transfer aborts the stream.
      snap = 1'b1;
      tick();
      snap = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid.valid", 32'(valid_a), 32'h0);
      chk("rstmid.busy", 32'(busy_a), 32'h0);
      chk("rstmid.last", 32'(last_a), 32'h0);
      repeat (3) tick();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 99) == 0);
         snap    = ($urandom_range(0, 7) == 0);
         ready   = ($urandom_range(0, 3) != 0);
         count_a = $urandom;
         count_b = {4'($urandom), 32'($urandom)};
         tick();
      end
      rst = 1'b0;
      wait_idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
